// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT types, reader states and helpers
package fft_pkg;
  typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_t;
  function automatic int cplx_width(input int w);
    return 2 * w;
  endfunction
  function automatic logic [31:0] bit_reverse(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = a[n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM with registered, resettable read port
module fft_reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  // write port, contents never cleared
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  // registered read that holds its value between reads and clears on reset
  always_ff @(posedge clock or negedge reset)
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fft_output_reorder.sv
// fft_output_reorder: bit-reversed to natural order frame reorder via ping-pong banks
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N_LOG2 = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_en,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);
  localparam int CW = cplx_width(WIDTH);
  logic [N_LOG2-1:0] w_cnt, r_cnt, w_rev;
  logic              w_bank, r_bank, w_last, rd, r_last;
  logic [1:0]        full;
  logic [CW-1:0]     rdata;
  rd_state_t         state, state_next;
  assign w_rev  = N_LOG2'(bit_reverse(32'(w_cnt), N_LOG2));
  assign w_last = in_en && &w_cnt;
  assign rd     = full[r_bank];
  assign r_last = rd && &r_cnt;
  // writer: advance on each accepted sample, swap bank after the last one
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      w_cnt  <= '0;
      w_bank <= 1'b0;
    end else if (in_en) begin
      w_cnt <= w_cnt + 1'b1;
      if (&w_cnt) w_bank <= ~w_bank;
    end
  // reader: a full bank is drained one word per cycle, then the bank swaps
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_cnt  <= '0;
      r_bank <= 1'b0;
    end else if (rd) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) r_bank <= ~r_bank;
    end
  // bank-full flags: writer sets and reader clears always target different banks
  always_ff @(posedge clock or negedge reset)
    if (!reset) full <= '0;
    else begin
      full[0] <= (w_last && !w_bank) || (full[0] && !(r_last && !r_bank));
      full[1] <= (w_last && w_bank) || (full[1] && !(r_last && r_bank));
    end
  // state register: READ while the output register carries a fresh word
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  // a read issued this cycle makes the next cycle an output cycle
  always_comb state_next = rd ? READ : IDLE;
  assign out_en = state == READ;
  assign {out_re, out_im} = rdata;
  fft_reorder_ram #(.AW(N_LOG2 + 1), .DW(CW)) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (in_en),
    .waddr ({w_bank, w_rev}),
    .wdata ({in_re, in_im}),
    .re    (rd),
    .raddr ({r_bank, r_cnt}),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: scoreboard bench for the output reorder buffer
module tb_fft_output_reorder;
  localparam int W = 16;
  localparam int NL = 3;
  localparam int N = 8;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_en = 1'b0;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic out_en;
  logic [W-1:0] out_re, out_im;
  typedef struct { logic [W-1:0] re; logic [W-1:0] im; } samp_t;
  typedef struct { logic [W-1:0] base; bit gap; bit lat; } vec_t;
  samp_t q[$];
  samp_t e;
  int errors = 0;
  int checks = 0;
  int run = 0;
  int max_run = 0;

  fft_output_reorder #(.WIDTH(W), .N_LOG2(NL)) dut (
    .clock  (clock),
    .reset  (reset),
    .in_en  (in_en),
    .in_re  (in_re),
    .in_im  (in_im),
    .out_en (out_en),
    .out_re (out_re),
    .out_im (out_im)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bitrev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  task automatic send_frame(input logic [W-1:0] base, input bit gap, input bit lat);
    for (int i = 0; i < N; i++) begin
      in_en = 1'b1;
      in_re = W'(base + bitrev3(i));
      in_im = W'(10 * (base + bitrev3(i)));
      @(posedge clock); #1;
      if (gap && i != N - 1) begin
        in_en = 1'b0;
        @(posedge clock); #1;
      end
    end
    in_en = 1'b0;
    for (int k = 0; k < N; k++) q.push_back('{re: W'(base + k), im: W'(10 * (base + k))});
    if (lat) begin
      @(negedge clock);
      chk("lat_not_yet", 32'(out_en), 0);
      @(negedge clock);
      chk("lat_first_en", 32'(out_en), 1);
      chk("lat_first_re", 32'(out_re), 32'(base));
      @(posedge clock); #1;
    end
  endtask

  // scoreboard and burst-contiguity monitor
  always @(negedge clock) begin
    if (!reset) run = 0;
    else if (out_en) begin
      run++;
      if (run > max_run) max_run = run;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got out_re=%0d expected no output", out_re);
      end else begin
        e = q.pop_front();
        chk("out_re", 32'(out_re), 32'(e.re));
        chk("out_im", 32'(out_im), 32'(e.im));
      end
    end else if (run > 0) begin
      chk("burst_len_mod8", 32'(run % N), 0);
      run = 0;
    end
  end

  initial begin
    vec_t tv[4];
    int t;
    tv[0] = '{base: 16'd0,  gap: 1'b0, lat: 1'b1};
    tv[1] = '{base: 16'd0,  gap: 1'b1, lat: 1'b1};
    tv[2] = '{base: 16'd50, gap: 1'b1, lat: 1'b1};
    tv[3] = '{base: 16'd70, gap: 1'b0, lat: 1'b1};
    #12;
    chk("rst_out_en", 32'(out_en), 0);
    chk("rst_out_re", 32'(out_re), 0);
    chk("rst_out_im", 32'(out_im), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    for (int v = 0; v < 4; v++) begin
      send_frame(tv[v].base, tv[v].gap, tv[v].lat);
      repeat (12) @(posedge clock);
      #1;
      chk("frame_drained", 32'(q.size()), 0);
    end
    max_run = 0;
    send_frame(16'd100, 1'b0, 1'b0);
    send_frame(16'd200, 1'b0, 1'b0);
    send_frame(16'd300, 1'b0, 1'b0);
    repeat (12) @(posedge clock);
    #1;
    chk("b2b_run", 32'(max_run), 24);
    chk("b2b_drained", 32'(q.size()), 0);
    for (int i = 0; i < 5; i++) begin
      in_en = 1'b1;
      in_re = W'(900 + i);
      in_im = W'(i);
      @(posedge clock); #1;
    end
    in_en = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    send_frame(16'd400, 1'b0, 1'b1);
    repeat (12) @(posedge clock);
    #1;
    chk("after_rst_drained", 32'(q.size()), 0);
    send_frame(16'd500, 1'b0, 1'b0);
    t = 0;
    while (!out_en && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    chk("wait_out_en", 32'(out_en), 1);
    repeat (3) @(posedge clock);
    #1;
    chk("mid_burst_re", 32'(out_re), 503);
    reset = 1'b0;
    #1;
    chk("async_rst_en", 32'(out_en), 0);
    chk("async_rst_re", 32'(out_re), 0);
    chk("async_rst_im", 32'(out_im), 0);
    q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    send_frame(16'd0, 1'b0, 1'b1);
    repeat (50) @(posedge clock);
    #1;
    chk("idle_en", 32'(out_en), 0);
    chk("idle_hold_re", 32'(out_re), 7);
    chk("idle_hold_im", 32'(out_im), 70);
    chk("final_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
